ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage; consumes the decoded bundle ID drives (op, regaData, regbData, regcWr, regcAddr).
//  Computes the write-back result for all CMD_* ops that ID emits.
//  Shifts (SLL/SRL/SRA) run on an iterative 1-bit/cycle shifter with a stall handshake.
//  All other ops complete in one cycle. Results are registered toward the MEM/WB end.
// PARAMETERS
//  DATA_W  32           operand/result width (= `REG_LENGTH)
//  ADDR_W  5            register address width (= `REG_ADDR_LEN)
//  OP_W    `OP_LENGTH   op code width; encodings are the CMD_* macros in ID.vh
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst        in   1       reset; synchronous, active-high
//  in_valid   in   1       decoded bundle on op/rega/regb/regc* is valid
//  in_ready   out  1       stage can accept; combinational, =1 only in IDLE
//  op         in   OP_W    CMD_* code from ID
//  regaData   in   DATA_W  operand A (rs; rt value for shifts; zero-ext imm for LUI)
//  regbData   in   DATA_W  operand B (rt, ext. imm, or shamt in [4:0])
//  regcWr_i   in   1       write enable from ID
//  regcAddr_i in   ADDR_W  destination register from ID
//  out_valid  out  1       result bundle valid (registered)
//  regcData   out  DATA_W  result (registered)
//  regcWr     out  1       write enable, passed through (registered)
//  regcAddr   out  ADDR_W  destination, passed through (registered)
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=IDLE, out_valid=0, regcData=0, regcWr=0, regcAddr=0, shift count=0.
//    Reset mid-shift aborts the op; no result is produced.
//  - Accept: edge where in_valid && in_ready. Inputs sampled only then.
//  - States: IDLE, SHIFT.
//    IDLE --accept shift op, shamt!=0--> SHIFT; otherwise stays IDLE.
//    SHIFT --last step--> IDLE.
//  - Single-cycle ops: at the accept edge load the result, regcWr<=regcWr_i, regcAddr<=regcAddr_i,
//    out_valid<=1. Latency 1 cycle. Back-to-back accepts every cycle are legal; out_valid stays 1.
//  - ADD/ADDI: A+B mod 2^DATA_W, no overflow trap. SUB: A-B mod 2^DATA_W.
//  - AND/ANDI, OR/ORI, XOR/XORI: bitwise A op B. LUI: A<<16.
//  - Shifts: shamt=regbData[4:0], upper bits ignored. SRL zero-fills; SRA replicates A[DATA_W-1].
//    - shamt=0: result=A, handled as single-cycle.
//    - shamt=n>0: at the accept edge acc<=A, cnt<=n, out_valid<=0, state<=SHIFT, regc* latched.
//    - Each SHIFT edge: acc shifted 1 bit, cnt-1.
//    - On the edge where cnt==1: regcData<=final value, out_valid<=1, state<=IDLE.
//    - Result is visible n+1 cycles after the accept cycle. in_ready=0 for n cycles.
//  - CMD_NONE or an unknown op: accepted, out_valid=1, regcWr=0, regcData=0.
//  - IDLE edge with no accept: out_valid<=0; regcData/regcWr/regcAddr hold their last values.
//  - out_valid is a 1-cycle pulse per op. The downstream always accepts; there is no backpressure input.
// CONFIGURATION
//  EX_BARREL_SHIFT_EN defined: shifts use a single-cycle barrel shifter.
//    SHIFT state is unused; in_ready is constantly 1; every op has latency 1.
//  EX_BARREL_SHIFT_EN undefined: iterative shifter exactly as above.
// TESTING
//  1 ADD A=0x7FFFFFFF B=1 addr=3 wr=1 -> next cycle out_valid=1, regcData=0x80000000, regcAddr=3.
//  2 SUB A=5 B=7 back-to-back with ORI A=0xF0 B=0x0F -> consecutive results 0xFFFFFFFE then 0x000000FF;
//    out_valid high 2 cycles.
//  3 SRA A=0x80000000 B=4 -> in_ready=0 for 4 cycles; 5th cycle out_valid=1, regcData=0xF8000000;
//    SLL B=0x20 (shamt 0) -> 1 cycle, regcData=A.
//  4 LUI A=0x00001234 -> 0x12340000; CMD_NONE -> out_valid=1, regcWr=0, regcData=0.
//  5 SRL A=0xFFFFFFFF B=31, rst=1 on 3rd SHIFT cycle -> next cycle state IDLE, in_ready=1,
//    out_valid=0, all outputs 0; no late result.
//  6 With EX_BARREL_SHIFT_EN: SRL A=0x80000000 B=31 -> next cycle regcData=1, in_ready never drops.

Source files
------------

// File: rtl/ex_if.sv
// Decoded-bundle interface between ID and EX, plus the registered EX result bundle.
interface ex_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int OP_W   = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] regaData;
    logic [DATA_W-1:0] regbData;
    logic              regcWr_i;
    logic [ADDR_W-1:0] regcAddr_i;
    logic              out_valid;
    logic [DATA_W-1:0] regcData;
    logic              regcWr;
    logic [ADDR_W-1:0] regcAddr;

    modport master (
        output in_valid, op, regaData, regbData, regcWr_i, regcAddr_i,
        input  in_ready, out_valid, regcData, regcWr, regcAddr
    );

    modport slave (
        input  in_valid, op, regaData, regbData, regcWr_i, regcAddr_i,
        output in_ready, out_valid, regcData, regcWr, regcAddr
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU ops plus an iterative 1-bit/cycle shifter with stall handshake.
// Define EX_BARREL_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module ex_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int OP_W   = 8
) (
    input logic   clk,
    input logic   rst,
    ex_if.slave   bus
);
    localparam logic [OP_W-1:0] CMD_NONE = OP_W'(0);
    localparam logic [OP_W-1:0] CMD_ADD  = OP_W'(1);
    localparam logic [OP_W-1:0] CMD_ADDI = OP_W'(2);
    localparam logic [OP_W-1:0] CMD_SUB  = OP_W'(3);
    localparam logic [OP_W-1:0] CMD_AND  = OP_W'(4);
    localparam logic [OP_W-1:0] CMD_ANDI = OP_W'(5);
    localparam logic [OP_W-1:0] CMD_OR   = OP_W'(6);
    localparam logic [OP_W-1:0] CMD_ORI  = OP_W'(7);
    localparam logic [OP_W-1:0] CMD_XOR  = OP_W'(8);
    localparam logic [OP_W-1:0] CMD_XORI = OP_W'(9);
    localparam logic [OP_W-1:0] CMD_LUI  = OP_W'(10);
    localparam logic [OP_W-1:0] CMD_SLL  = OP_W'(11);
    localparam logic [OP_W-1:0] CMD_SRL  = OP_W'(12);
    localparam logic [OP_W-1:0] CMD_SRA  = OP_W'(13);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    localparam logic [1:0] K_SLL = 2'd0;
    localparam logic [1:0] K_SRL = 2'd1;
    localparam logic [1:0] K_SRA = 2'd2;

    logic [0:0]        state_p1;
    logic [DATA_W-1:0] acc_p1;
    logic [4:0]        cnt_p1;
    logic [1:0]        kind_p1;

    logic              accept;
    logic              is_shift;
    logic              known_op;
    logic              start_shift;
    logic [4:0]        shamt;
    logic [1:0]        kind;

    function automatic logic [DATA_W-1:0] shift_one(input logic [1:0] k, input logic [DATA_W-1:0] a);
        case (k)
            K_SLL:   return {a[DATA_W-2:0], 1'b0};
            K_SRL:   return {1'b0, a[DATA_W-1:1]};
            default: return {a[DATA_W-1], a[DATA_W-1:1]};
        endcase
    endfunction

`ifdef EX_BARREL_SHIFT_EN
    function automatic logic [DATA_W-1:0] shift_full(input logic [1:0] k, input logic [DATA_W-1:0] a,
                                                     input logic [4:0] n);
        logic signed [DATA_W-1:0] sa;
        sa = a;
        case (k)
            K_SLL:   return a << n;
            K_SRL:   return a >> n;
            default: return sa >>> n;
        endcase
    endfunction
`endif

    // Shifts reach here only with shamt==0 unless the barrel shifter is built in.
    function automatic logic [DATA_W-1:0] alu(input logic [OP_W-1:0] o, input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b, input logic [1:0] k);
        case (o)
            CMD_ADD, CMD_ADDI: return a + b;
            CMD_SUB:           return a - b;
            CMD_AND, CMD_ANDI: return a & b;
            CMD_OR,  CMD_ORI:  return a | b;
            CMD_XOR, CMD_XORI: return a ^ b;
            CMD_LUI:           return a << 16;
`ifdef EX_BARREL_SHIFT_EN
            CMD_SLL, CMD_SRL, CMD_SRA: return shift_full(k, a, b[4:0]);
`else
            CMD_SLL, CMD_SRL, CMD_SRA: return (k == K_SRA) ? a : a;
`endif
            default:           return '0;
        endcase
    endfunction

    always_comb begin
        shamt    = bus.regbData[4:0];
        is_shift = (bus.op == CMD_SLL) || (bus.op == CMD_SRL) || (bus.op == CMD_SRA);
        known_op = (bus.op != CMD_NONE) && (bus.op <= CMD_SRA);
        kind     = (bus.op == CMD_SLL) ? K_SLL : (bus.op == CMD_SRL) ? K_SRL : K_SRA;
`ifdef EX_BARREL_SHIFT_EN
        bus.in_ready = 1'b1;
        start_shift  = 1'b0;
`else
        bus.in_ready = (state_p1 == IDLE);
        start_shift  = is_shift && (shamt != 5'd0);
`endif
        accept = bus.in_valid && bus.in_ready;
    end

    // Stage p1: result/control registers toward MEM/WB
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p1      <= IDLE;
            cnt_p1        <= 5'd0;
            bus.out_valid <= 1'b0;
            bus.regcData  <= '0;
            bus.regcWr    <= 1'b0;
            bus.regcAddr  <= '0;
        end else begin
            case (state_p1)
                SHIFT: begin
                    acc_p1 <= shift_one(kind_p1, acc_p1);
                    cnt_p1 <= cnt_p1 - 5'd1;
                    if (cnt_p1 == 5'd1) begin
                        bus.regcData  <= shift_one(kind_p1, acc_p1);
                        bus.out_valid <= 1'b1;
                        state_p1      <= IDLE;
                    end else begin
                        bus.out_valid <= 1'b0;
                    end
                end
                default: begin
                    if (accept) begin
                        bus.regcWr   <= bus.regcWr_i && known_op;
                        bus.regcAddr <= bus.regcAddr_i;
                        if (start_shift) begin
                            acc_p1        <= bus.regaData;
                            cnt_p1        <= shamt;
                            kind_p1       <= kind;
                            bus.out_valid <= 1'b0;
                            state_p1      <= SHIFT;
                        end else begin
                            bus.regcData  <= alu(bus.op, bus.regaData, bus.regbData, kind);
                            bus.out_valid <= 1'b1;
                        end
                    end else begin
                        bus.out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed table, hand sequences, and randomized ops vs. a reference model.
module tb_ex_stage;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int OP_W   = 8;

    localparam logic [7:0] C_NONE = 8'd0,  C_ADD = 8'd1,  C_ADDI = 8'd2, C_SUB = 8'd3,
                           C_AND  = 8'd4,  C_ANDI = 8'd5, C_OR  = 8'd6,  C_ORI = 8'd7,
                           C_XOR  = 8'd8,  C_XORI = 8'd9, C_LUI = 8'd10, C_SLL = 8'd11,
                           C_SRL  = 8'd12, C_SRA  = 8'd13;

`ifdef EX_BARREL_SHIFT_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W)) bus ();

    ex_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    endtask

    // Reference model written from the op definitions
    function automatic logic [31:0] model_data(input logic [7:0] o, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = int'(b[4:0]);
        case (o)
            C_ADD, C_ADDI: return a + b;
            C_SUB:         return a + (~b) + 32'd1;
            C_AND, C_ANDI: return a & b;
            C_OR,  C_ORI:  return a | b;
            C_XOR, C_XORI: return a ^ b;
            C_LUI:         return {a[15:0], 16'h0000};
            C_SLL:         return a << n;
            C_SRL:         return a >> n;
            C_SRA:         return (a >> n) | (a[31] ? ~(32'hFFFF_FFFF >> n) : 32'h0);
            default:       return 32'h0;
        endcase
    endfunction

    function automatic bit model_known(input logic [7:0] o);
        return (o >= C_ADD) && (o <= C_SRA);
    endfunction

    function automatic int model_lat(input logic [7:0] o, input logic [31:0] b);
        if (!BARREL && (o == C_SLL || o == C_SRL || o == C_SRA) && b[4:0] != 5'd0)
            return int'(b[4:0]) + 1;
        return 1;
    endfunction

    task automatic idle_inputs();
        bus.in_valid   = 1'b0;
        bus.op         = '0;
        bus.regaData   = '0;
        bus.regbData   = '0;
        bus.regcWr_i   = 1'b0;
        bus.regcAddr_i = '0;
    endtask

    // Issue one op in isolation and check latency, stall length, result and the 1-cycle pulse.
    task automatic run_op(input string name, input logic [7:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic wr, input logic [4:0] addr);
        int lat, busy, w;
        logic [31:0] exp_d;
        w = 0;
        while (!bus.in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        bus.in_valid = 1'b1; bus.op = o; bus.regaData = a; bus.regbData = b;
        bus.regcWr_i = wr; bus.regcAddr_i = addr;
        lat = -1; busy = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == 1) idle_inputs();
            if (bus.out_valid) begin
                lat = k;
                break;
            end
            if (!bus.in_ready) busy++;
        end
        exp_d = model_data(o, a, b);
        chk({name, " latency"}, lat, model_lat(o, b));
        chk({name, " stall"}, busy, model_lat(o, b) - 1);
        chk({name, " data"}, bus.regcData, exp_d);
        chk({name, " wr"}, {31'd0, bus.regcWr}, {31'd0, wr & model_known(o)});
        chk({name, " addr"}, {27'd0, bus.regcAddr}, {27'd0, addr});
        @(negedge clk);
        chk({name, " pulse"}, {31'd0, bus.out_valid}, 32'd0);
    endtask

    typedef struct {
        string      name;
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vec_t v;
        bit late;
        rst = 1'b1;
        idle_inputs();

        vecs.push_back('{"add_ovf", C_ADD,  32'h7FFF_FFFF, 32'h1,  1'b1, 5'd3,  32'h8000_0000});
        vecs.push_back('{"sub",     C_SUB,  32'd5,         32'd7,  1'b1, 5'd4,  32'hFFFF_FFFE});
        vecs.push_back('{"ori",     C_ORI,  32'hF0,        32'h0F, 1'b1, 5'd5,  32'h0000_00FF});
        vecs.push_back('{"andi",    C_ANDI, 32'hF0F0_1234, 32'hFF, 1'b1, 5'd6,  32'h0000_0034});
        vecs.push_back('{"xor",     C_XOR,  32'hAAAA_5555, 32'hFFFF_0000, 1'b1, 5'd7, 32'h5555_5555});
        vecs.push_back('{"sra4",    C_SRA,  32'h8000_0000, 32'd4,  1'b1, 5'd8,  32'hF800_0000});
        vecs.push_back('{"sll0",    C_SLL,  32'hDEAD_BEEF, 32'h20, 1'b1, 5'd9,  32'hDEAD_BEEF});
        vecs.push_back('{"sll3",    C_SLL,  32'h1000_0001, 32'd3,  1'b1, 5'd10, 32'h8000_0008});
        vecs.push_back('{"lui",     C_LUI,  32'h0000_1234, 32'h0,  1'b1, 5'd11, 32'h1234_0000});
        vecs.push_back('{"none",    C_NONE, 32'h1234_5678, 32'h9,  1'b1, 5'd12, 32'h0});
        vecs.push_back('{"unknown", 8'h3F,  32'h1234_5678, 32'h9,  1'b1, 5'd13, 32'h0});
        vecs.push_back('{"srl31",   C_SRL,  32'h8000_0000, 32'd31, 1'b0, 5'd14, 32'h0000_0001});

        repeat (2) @(negedge clk);
        chk("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst regcData", bus.regcData, 32'd0);
        chk("rst regcWr", {31'd0, bus.regcWr}, 32'd0);
        chk("rst regcAddr", {27'd0, bus.regcAddr}, 32'd0);
        chk("rst in_ready", {31'd0, bus.in_ready}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            v = vecs[i];
            chk({v.name, " table"}, model_data(v.op, v.a, v.b), v.exp_data);
            run_op(v.name, v.op, v.a, v.b, v.wr, v.addr);
        end

        // Back-to-back SUB then ORI
        bus.in_valid = 1'b1; bus.op = C_SUB; bus.regaData = 32'd5; bus.regbData = 32'd7;
        bus.regcWr_i = 1'b1; bus.regcAddr_i = 5'd1;
        @(negedge clk);
        chk("b2b first valid", {31'd0, bus.out_valid}, 32'd1);
        chk("b2b first data", bus.regcData, 32'hFFFF_FFFE);
        bus.op = C_ORI; bus.regaData = 32'hF0; bus.regbData = 32'h0F; bus.regcAddr_i = 5'd2;
        @(negedge clk);
        idle_inputs();
        chk("b2b second valid", {31'd0, bus.out_valid}, 32'd1);
        chk("b2b second data", bus.regcData, 32'h0000_00FF);
        chk("b2b second addr", {27'd0, bus.regcAddr}, 32'd2);
        @(negedge clk);
        chk("b2b valid drop", {31'd0, bus.out_valid}, 32'd0);

`ifndef EX_BARREL_SHIFT_EN
        // Reset on the 3rd SHIFT cycle aborts the shift
        bus.in_valid = 1'b1; bus.op = C_SRL; bus.regaData = 32'hFFFF_FFFF; bus.regbData = 32'd31;
        bus.regcWr_i = 1'b1; bus.regcAddr_i = 5'd17;
        @(negedge clk);
        idle_inputs();
        chk("abort busy", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("abort out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("abort regcData", bus.regcData, 32'd0);
        chk("abort regcWr", {31'd0, bus.regcWr}, 32'd0);
        chk("abort regcAddr", {27'd0, bus.regcAddr}, 32'd0);
        late = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) late = 1'b1;
        end
        chk("abort no late result", {31'd0, late}, 32'd0);
`endif

        // Randomized ops against the reference model
        for (int i = 0; i < 60; i++) begin
            logic [7:0]  o;
            logic [31:0] a, b;
            o = 8'($urandom_range(0, 14));
            if (o == 8'd14) o = 8'h20;
            a = $urandom;
            b = $urandom;
            run_op($sformatf("rand%0d", i), o, a, b, 1'($urandom), 5'($urandom));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
